// File: rtl/mod_mem_responder.sv
// rtl/mod_mem_responder.sv - unified instruction/data memory responder with hold-based CPU stall
// Optional feature: MEM_RESP_ERR_EN adds the sticky mem_err address-fault flag.
`timescale 1ns/1ps
module mod_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic [31:0]       data_address,
    input  logic [31:0]       write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic [31:0]       instruction,
    output logic [31:0]       data,
    output logic              hold
`ifdef MEM_RESP_ERR_EN
    ,
    output logic              mem_err
`endif
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_FETCH, S_CHECK, S_DATA, S_RELEASE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              rd_q, wr_q;
    logic              cnt_last;
    logic              fetch_cap, data_cap;
    logic [ADDR_W-1:0] pc_idx, data_idx;
    logic [31:0]       mem [DEPTH];

    assign pc_idx    = pc[ADDR_W+1:2];
    assign data_idx  = data_address[ADDR_W+1:2];
    assign cnt_last  = (cnt == CNT_LAST);
    assign fetch_cap = (state == S_FETCH) && cnt_last;
    assign data_cap  = (state == S_DATA) && cnt_last;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_FETCH: begin
                if (cnt_last) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = S_CHECK;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_CHECK:   state_nxt = (mem_read || mem_write) ? S_DATA : S_RELEASE;
            S_DATA: begin
                if (cnt_last) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = S_RELEASE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_RELEASE: state_nxt = S_FETCH;
            default:   state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            cnt         <= 4'd0;
            hold        <= 1'b1;
            instruction <= 32'd0;
            data        <= 32'd0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hold  <= (state_nxt != S_RELEASE);
            if (fetch_cap)
                instruction <= mem[pc_idx];
            if (state == S_CHECK) begin
                rd_q <= mem_read;
                wr_q <= mem_write;
            end
            // a combined read+write request is treated as a store; data keeps its old value
            if (data_cap && !wr_q && rd_q)
                data <= mem[data_idx];
        end
    end

    // Preload only while reset is held; stores are suppressed by reset so an aborted access never writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (load_en)
                mem[load_addr] <= load_data;
        end else if (data_cap && wr_q) begin
            mem[data_idx] <= write_data;
        end
    end

`ifdef MEM_RESP_ERR_EN
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            mem_err <= 1'b0;
        else if ((fetch_cap && addr_bad(pc)) || (data_cap && addr_bad(data_address)))
            mem_err <= 1'b1;
    end
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc[31:ADDR_W+2], pc[1:0], data_address[31:ADDR_W+2], data_address[1:0]};
`endif
endmodule

// File: tb/tb_mod_mem_responder.sv
// tb/tb_mod_mem_responder.sv - directed self-checking bench for mod_mem_responder
`timescale 1ns/1ps
module tb_mod_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'd0, data_address = 32'd0, write_data = 32'd0;
    logic        mem_read = 1'b0, mem_write = 1'b0, load_en = 1'b0;
    logic [9:0]  load_addr = 10'd0;
    logic [31:0] load_data = 32'd0;
    logic [31:0] instr2, data2, instr1, data1, instr15, data15;
    logic        hold2, hold1, hold15;
`ifdef MEM_RESP_ERR_EN
    logic        err2, err1, err15;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mod_mem_responder #(.ADDR_W(10), .LATENCY(2)) u2 (
        .clk(clk), .reset(reset), .pc(pc), .data_address(data_address), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .instruction(instr2), .data(data2), .hold(hold2)
`ifdef MEM_RESP_ERR_EN
        , .mem_err(err2)
`endif
    );
    mod_mem_responder #(.ADDR_W(10), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .pc(pc), .data_address(data_address), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .instruction(instr1), .data(data1), .hold(hold1)
`ifdef MEM_RESP_ERR_EN
        , .mem_err(err1)
`endif
    );
    mod_mem_responder #(.ADDR_W(10), .LATENCY(15)) u15 (
        .clk(clk), .reset(reset), .pc(pc), .data_address(data_address), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .instruction(instr15), .data(data15), .hold(hold15)
`ifdef MEM_RESP_ERR_EN
        , .mem_err(err15)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    // Advance until hold drops; n is the 1-based cycle of the instruction on which hold=0.
    task automatic run_instr(output int n);
        n = 1;
        while (hold2 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        logic exp_hold [4];
        exp_hold = '{1'b1, 1'b1, 1'b1, 1'b0};
        reset = 1'b1;
        pc = 32'd0; mem_read = 1'b0; mem_write = 1'b0;
        preload(10'd0, 32'h2008_0005);
        total++;
        if (hold2 !== 1'b1 || instr2 !== 32'd0 || data2 !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: hold=%0b instr=%h data=%h, want hold=1 instr=0 data=0", hold2, instr2, data2);
        end
`ifdef MEM_RESP_ERR_EN
        total++;
        if (err2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mem_err: got %0b want 0", err2);
        end
`endif
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (hold2 !== exp_hold[c]) begin
                bad++;
                $display("FAIL fetch_hold_c%0d: got %0b want %0b", c + 1, hold2, exp_hold[c]);
            end
            if (c >= 2) begin
                total++;
                if (instr2 !== 32'h2008_0005) begin
                    bad++;
                    $display("FAIL fetch_instr_c%0d: got %h want 20080005", c + 1, instr2);
                end
            end
            if (c < 3) tick();
        end
    endtask

    task automatic test_load();
        int n;
        reset = 1'b1;
        preload(10'd1, 32'h8C09_0010);
        preload(10'd4, 32'hDEAD_BEEF);
        pc = 32'd4; data_address = 32'h10; mem_read = 1'b1; mem_write = 1'b0;
        reset = 1'b0;
        run_instr(n);
        total++;
        if (n !== 6 || data2 !== 32'hDEAD_BEEF || instr2 !== 32'h8C09_0010) begin
            bad++;
            $display("FAIL load: cycles=%0d data=%h instr=%h, want 6 deadbeef 8c090010", n, data2, instr2);
        end
        tick();
        total++;
        if (hold2 !== 1'b1) begin
            bad++;
            $display("FAIL load_single_release: hold=%0b want 1", hold2);
        end
    endtask

    task automatic test_store_load();
        int n;
        mem_read = 1'b0; mem_write = 1'b1; data_address = 32'h10; write_data = 32'h1234_5678;
        run_instr(n);
        total++;
        if (n !== 6 || data2 !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL store: cycles=%0d data=%h, want 6 deadbeef", n, data2);
        end
        tick();
        mem_write = 1'b0; mem_read = 1'b1; pc = 32'h10;
        run_instr(n);
        total++;
        if (n !== 6 || data2 !== 32'h1234_5678) begin
            bad++;
            $display("FAIL store_then_load: cycles=%0d data=%h, want 6 12345678", n, data2);
        end
        total++;
        if (instr2 !== 32'h1234_5678) begin
            bad++;
            $display("FAIL store_then_fetch: instr=%h want 12345678", instr2);
        end
        tick();
    endtask

    task automatic test_reset_mid_store();
        int n;
        reset = 1'b1;
        preload(10'd5, 32'hAAAA_5555);
        pc = 32'd0; mem_read = 1'b0; mem_write = 1'b1; data_address = 32'h14; write_data = 32'hFFFF_0000;
        reset = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        total++;
        if (hold2 !== 1'b1 || instr2 !== 32'd0 || data2 !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset_state: hold=%0b instr=%h data=%h, want 1 0 0", hold2, instr2, data2);
        end
        mem_write = 1'b0; mem_read = 1'b1;
        reset = 1'b0;
        run_instr(n);
        total++;
        if (n !== 6 || data2 !== 32'hAAAA_5555) begin
            bad++;
            $display("FAIL aborted_store: cycles=%0d data=%h, want 6 aaaa5555", n, data2);
        end
        total++;
        if (instr2 !== 32'h2008_0005) begin
            bad++;
            $display("FAIL refetch_pc0: instr=%h want 20080005", instr2);
        end
        tick();
    endtask

    task automatic test_rw_wrap();
        int n;
        mem_read = 1'b1; mem_write = 1'b1; data_address = 32'h8; write_data = 32'h0BAD_F00D;
        run_instr(n);
        total++;
        if (n !== 6 || data2 !== 32'hAAAA_5555) begin
            bad++;
            $display("FAIL read_write_both: cycles=%0d data=%h, want 6 aaaa5555", n, data2);
        end
`ifdef MEM_RESP_ERR_EN
        total++;
        if (err2 !== 1'b0) begin
            bad++;
            $display("FAIL mem_err_clean: got %0b want 0", err2);
        end
`endif
        tick();
        mem_write = 1'b0; data_address = 32'h1008;
        run_instr(n);
        total++;
        if (n !== 6 || data2 !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL wrap_load: cycles=%0d data=%h, want 6 0badf00d", n, data2);
        end
`ifdef MEM_RESP_ERR_EN
        total++;
        if (err2 !== 1'b1) begin
            bad++;
            $display("FAIL mem_err_wrap: got %0b want 1", err2);
        end
`endif
        tick();
    endtask

    task automatic test_latency_sweep();
        logic h1 [41];
        logic h15 [41];
        int f1, f15;
        int e1  [2];
        int e15 [2];
        e1  = '{3, 4};
        e15 = '{17, 32};
        for (int k = 0; k < 2; k++) begin
            reset = 1'b1;
            pc = 32'd0; data_address = 32'h10; mem_write = 1'b0; mem_read = (k == 1);
            tick();
            reset = 1'b0;
            for (int c = 1; c <= 40; c++) begin
                h1[c]  = hold1;
                h15[c] = hold15;
                tick();
            end
            f1 = 0;
            f15 = 0;
            for (int c = 1; c <= 39; c++) begin
                if (f1 == 0 && h1[c] === 1'b0) f1 = c;
                if (f15 == 0 && h15[c] === 1'b0) f15 = c;
            end
            total++;
            if (f1 !== e1[k] || h1[f1 + 1] !== 1'b1) begin
                bad++;
                $display("FAIL latency1_k%0d: release at cycle %0d next hold=%0b, want %0d then 1", k, f1, h1[f1 + 1], e1[k]);
            end
            total++;
            if (f15 !== e15[k] || h15[f15 + 1] !== 1'b1) begin
                bad++;
                $display("FAIL latency15_k%0d: release at cycle %0d next hold=%0b, want %0d then 1", k, f15, h15[f15 + 1], e15[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_load();
        test_reset_mid_store();
        test_rw_wrap();
        test_latency_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
